// File: rtl/decode_stage_pipe_pkg.sv
// Shared decode-stage definitions: extender modes, NOP encoding and
// instruction field positions used to slice rs, rt and the immediate.
package decode_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_LUI  = 2'b10
    } ext_op_e;

    localparam logic [31:0] INSTR_NOP = '0;

    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Decode-stage bus: controller/hazard-unit inputs, W-stage write port,
// forwarded operands, and the combinational and D/E register outputs.
// master drives the stage, slave is the decode stage itself.
interface decode_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [31:0]       Instr_D;
    logic [DATA_W-1:0] PC_D;
    logic [1:0]        EXTOp;
    logic [REG_AW-1:0] A3D;
    logic              IsMulDiv_D;
    logic              MD_Start;
    logic              MD_IsDiv;
    logic              Stall_In;
    logic              Flush_E;
    logic              RFWr;
    logic [REG_AW-1:0] A3W;
    logic [DATA_W-1:0] WData;
    logic [DATA_W-1:0] PC_W;
    logic [DATA_W-1:0] FWD_D1;
    logic [DATA_W-1:0] FWD_D2;

    logic [DATA_W-1:0] RD1D;
    logic [DATA_W-1:0] RD2D;
    logic              Cmp_Eq;
    logic              Cmp_GeZ;
    logic              Cmp_GtZ;
    logic              Stall;
    logic              MD_Busy;
    logic [31:0]       Instr_E;
    logic [DATA_W-1:0] PC_E;
    logic [DATA_W-1:0] RS_E;
    logic [DATA_W-1:0] RT_E;
    logic [DATA_W-1:0] EXT_E;
    logic [REG_AW-1:0] A3E;

    modport master (
        output Instr_D, PC_D, EXTOp, A3D, IsMulDiv_D, MD_Start, MD_IsDiv,
               Stall_In, Flush_E, RFWr, A3W, WData, PC_W, FWD_D1, FWD_D2,
        input  RD1D, RD2D, Cmp_Eq, Cmp_GeZ, Cmp_GtZ, Stall, MD_Busy,
               Instr_E, PC_E, RS_E, RT_E, EXT_E, A3E
    );

    modport slave (
        input  Instr_D, PC_D, EXTOp, A3D, IsMulDiv_D, MD_Start, MD_IsDiv,
               Stall_In, Flush_E, RFWr, A3W, WData, PC_W, FWD_D1, FWD_D2,
        output RD1D, RD2D, Cmp_Eq, Cmp_GeZ, Cmp_GtZ, Stall, MD_Busy,
               Instr_E, PC_E, RS_E, RT_E, EXT_E, A3E
    );
endinterface

// File: rtl/decode_stage_pipe_grf.sv
// General register file: 2^REG_AW registers, $0 hardwired to zero,
// synchronous clear, one write port with same-cycle write-through to both
// read ports. Optional write log enabled by GRF_WRITE_LOG_EN.
module grf_bank #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [REG_AW-1:0] a1,
    input  logic [REG_AW-1:0] a2,
    input  logic [REG_AW-1:0] a3,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] pc_w,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    localparam int unsigned NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] regs [NREG];

    // Storage: clear everything on reset, otherwise commit non-$0 writes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (a3 != '0)) begin
            regs[a3] <= wdata;
        end
    end

    // Read ports: $0 is zero, a matching W-stage write wins over storage.
    always_comb begin
        rd1 = regs[a1];
        if (a1 == '0) begin
            rd1 = '0;
        end else if (we && (a3 == a1)) begin
            rd1 = wdata;
        end
        rd2 = regs[a2];
        if (a2 == '0) begin
            rd2 = '0;
        end else if (we && (a3 == a2)) begin
            rd2 = wdata;
        end
    end

`ifdef GRF_WRITE_LOG_EN
    // Write log: one line per committed register write.
    always_ff @(posedge clk) begin
        if (reset_n && we && (a3 != '0)) begin
            $display("@%h: $%0d <= %h", pc_w, a3, wdata);
        end
    end
`else
    logic unused_pc_w;
    assign unused_pc_w = ^pc_w;
`endif

endmodule

// File: rtl/decode_stage_pipe.sv
// MIPS decode stage: register file with write-through, immediate extender,
// branch comparator, multiply/divide busy counter with stall request, and
// the D/E pipeline register with bubble insertion.
// Build option: GRF_WRITE_LOG_EN enables the register write log in grf_bank.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    decode_stage_pipe_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DIV_LAT + 1);

    logic [REG_AW-1:0] a1;
    logic [REG_AW-1:0] a2;
    logic [15:0]       imm;
    logic [DATA_W-1:0] ext_out;
    logic [CNT_W-1:0]  md_cnt;
    logic              md_busy;
    logic              stall;

    // Register addresses are resized to the file's address width.
    assign a1  = REG_AW'(bus.Instr_D[RS_MSB:RS_LSB]);
    assign a2  = REG_AW'(bus.Instr_D[RT_MSB:RT_LSB]);
    assign imm = bus.Instr_D[IMM_MSB:IMM_LSB];

    grf_bank #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_grf (
        .clk     (Clk),
        .reset_n (Reset),
        .we      (bus.RFWr),
        .a1      (a1),
        .a2      (a2),
        .a3      (bus.A3W),
        .wdata   (bus.WData),
        .pc_w    (bus.PC_W),
        .rd1     (bus.RD1D),
        .rd2     (bus.RD2D)
    );

    // Immediate extender; lui builds a 32-bit word which is then resized.
    always_comb begin
        ext_out = '0;
        case (bus.EXTOp)
            EXT_ZERO: ext_out = DATA_W'(imm);
            EXT_SIGN: begin
                ext_out       = {DATA_W{imm[15]}};
                ext_out[15:0] = imm;
            end
            EXT_LUI:  ext_out = DATA_W'({imm, 16'h0000});
            default:  ext_out = '0;
        endcase
    end

    // Branch comparator on the forwarded operands.
    assign bus.Cmp_Eq  = (bus.FWD_D1 == bus.FWD_D2);
    assign bus.Cmp_GeZ = ~bus.FWD_D1[DATA_W-1];
    assign bus.Cmp_GtZ = ~bus.FWD_D1[DATA_W-1] & (|bus.FWD_D1);

    // MDU busy counter: loads only when idle, otherwise counts down.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            md_cnt <= '0;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end else if (bus.MD_Start) begin
            md_cnt <= bus.MD_IsDiv ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end
    end

    assign md_busy     = (md_cnt != '0);
    assign stall       = bus.Stall_In | (md_busy & bus.IsMulDiv_D);
    assign bus.MD_Busy = md_busy;
    assign bus.Stall   = stall;

    // D/E register: reset, then bubble (PC still advances), then normal load.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            bus.Instr_E <= INSTR_NOP;
            bus.PC_E    <= '0;
            bus.RS_E    <= '0;
            bus.RT_E    <= '0;
            bus.EXT_E   <= '0;
            bus.A3E     <= '0;
        end else if (bus.Flush_E || stall) begin
            bus.Instr_E <= INSTR_NOP;
            bus.PC_E    <= bus.PC_D;
            bus.RS_E    <= '0;
            bus.RT_E    <= '0;
            bus.EXT_E   <= '0;
            bus.A3E     <= '0;
        end else begin
            bus.Instr_E <= bus.Instr_D;
            bus.PC_E    <= bus.PC_D;
            bus.RS_E    <= bus.FWD_D1;
            bus.RT_E    <= bus.FWD_D2;
            bus.EXT_E   <= ext_out;
            bus.A3E     <= bus.A3D;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Testbench for decode_stage_pipe: directed vectors with literal checks,
// plus a cycle-level reference model compared on every falling edge.
module tb_decode_stage_pipe;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int ML = 5;
    localparam int DL = 10;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    decode_stage_pipe_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    decode_stage_pipe #(
        .DATA_W  (DW),
        .REG_AW  (AW),
        .MUL_LAT (ML),
        .DIV_LAT (DL)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'd0, rs, rt, imm};
    endfunction

    function automatic logic [DW-1:0] ext_model(input logic [1:0] op, input logic [15:0] imm);
        case (op)
            2'd0: return {16'h0000, imm};
            2'd1: return imm[15] ? (32'hFFFF_0000 | {16'h0000, imm}) : {16'h0000, imm};
            2'd2: return {imm, 16'h0000};
            default: return '0;
        endcase
    endfunction

    // Reference model: architectural registers, busy window as an end-cycle
    // number, and the expected D/E register contents.
    logic [DW-1:0] mreg [0:31];
    int cyc = 0;
    int busy_until = 0;
    bit mvalid = 0;
    logic [31:0] e_instr;
    logic [DW-1:0] e_pc, e_rs, e_rt, e_ext;
    logic [AW-1:0] e_a3;

    always @(posedge Clk) begin
        automatic bit busy_now = (cyc < busy_until);
        automatic bit st = bus.Stall_In || (busy_now && bus.IsMulDiv_D);
        cyc <= cyc + 1;
        if (!Reset) begin
            for (int i = 0; i < 32; i++) mreg[i] <= '0;
            busy_until <= 0;
            mvalid <= 1'b1;
            e_instr <= '0; e_pc <= '0; e_rs <= '0; e_rt <= '0; e_ext <= '0; e_a3 <= '0;
        end else begin
            if (bus.RFWr && bus.A3W != 0) mreg[bus.A3W] <= bus.WData;
            if (bus.MD_Start && !busy_now) busy_until <= cyc + 1 + (bus.MD_IsDiv ? DL : ML);
            if (bus.Flush_E || st) begin
                e_instr <= '0; e_pc <= bus.PC_D; e_rs <= '0; e_rt <= '0; e_ext <= '0; e_a3 <= '0;
            end else begin
                e_instr <= bus.Instr_D;
                e_pc    <= bus.PC_D;
                e_rs    <= bus.FWD_D1;
                e_rt    <= bus.FWD_D2;
                e_ext   <= ext_model(bus.EXTOp, bus.Instr_D[15:0]);
                e_a3    <= bus.A3D;
            end
        end
    end

    function automatic logic [DW-1:0] rd_model(input logic [4:0] a);
        if (a == 0) return '0;
        if (bus.RFWr && bus.A3W == a) return bus.WData;
        return mreg[a];
    endfunction

    // Compare process: every falling edge once the model has seen reset.
    always @(negedge Clk) begin
        if (mvalid) begin
            automatic bit busy_now = (cyc < busy_until);
            chk("m_rd1", bus.RD1D, rd_model(bus.Instr_D[25:21]));
            chk("m_rd2", bus.RD2D, rd_model(bus.Instr_D[20:16]));
            chk("m_eq", bus.Cmp_Eq, bus.FWD_D1 == bus.FWD_D2);
            chk("m_gez", bus.Cmp_GeZ, $signed(bus.FWD_D1) >= 0);
            chk("m_gtz", bus.Cmp_GtZ, $signed(bus.FWD_D1) > 0);
            chk("m_busy", bus.MD_Busy, busy_now);
            chk("m_stall", bus.Stall, bus.Stall_In || (busy_now && bus.IsMulDiv_D));
            chk("m_instr_e", bus.Instr_E, e_instr);
            chk("m_pc_e", bus.PC_E, e_pc);
            chk("m_rs_e", bus.RS_E, e_rs);
            chk("m_rt_e", bus.RT_E, e_rt);
            chk("m_ext_e", bus.EXT_E, e_ext);
            chk("m_a3e", bus.A3E, e_a3);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.Instr_D = '0; bus.PC_D = '0; bus.EXTOp = '0; bus.A3D = '0;
        bus.IsMulDiv_D = 0; bus.MD_Start = 0; bus.MD_IsDiv = 0; bus.Stall_In = 0;
        bus.Flush_E = 0; bus.RFWr = 0; bus.A3W = '0; bus.WData = '0; bus.PC_W = '0;
        bus.FWD_D1 = '0; bus.FWD_D2 = '0;

        // Reset for two cycles
        Reset = 0;
        tick(); tick();
        Reset = 1;
        chk("rst_instr_e", bus.Instr_E, 32'h0);
        chk("rst_pc_e", bus.PC_E, 32'h0);
        chk("rst_busy", bus.MD_Busy, 1'b0);
        chk("rst_eq", bus.Cmp_Eq, 1'b1);
        chk("rst_gez", bus.Cmp_GeZ, 1'b1);
        bus.Instr_D = mk(5'd5, 5'd0, 16'h0);
        #1 chk("rst_rd5", bus.RD1D, 32'h0);
        tick();

        // Write-through and storage
        bus.RFWr = 1; bus.A3W = 5'd8; bus.WData = 32'hDEADBEEF; bus.PC_W = 32'h3000;
        bus.Instr_D = mk(5'd8, 5'd0, 16'h0);
        #1 chk("bypass_rd1", bus.RD1D, 32'hDEADBEEF);
        tick();
        bus.A3W = 5'd9; bus.WData = 32'h0BADF00D;
        tick();
        bus.RFWr = 0;
        bus.Instr_D = mk(5'd8, 5'd9, 16'h0);
        #1 chk("store_rd1", bus.RD1D, 32'hDEADBEEF);
        chk("store_rd2", bus.RD2D, 32'h0BADF00D);
        bus.RFWr = 1; bus.A3W = 5'd0; bus.WData = 32'h12345678;
        bus.Instr_D = mk(5'd0, 5'd8, 16'h0);
        #1 chk("zero_bypass", bus.RD1D, 32'h0);
        tick();
        bus.RFWr = 0;
        #1 chk("zero_store", bus.RD1D, 32'h0);

        // Extender through the D/E register
        bus.PC_D = 32'h100; bus.A3D = 5'd3;
        bus.EXTOp = 2'b01; bus.Instr_D = mk(5'd1, 5'd2, 16'h8000);
        tick();
        chk("ext_sign", bus.EXT_E, 32'hFFFF8000);
        chk("ext_instr", bus.Instr_E, mk(5'd1, 5'd2, 16'h8000));
        chk("ext_a3e", bus.A3E, 5'd3);
        bus.EXTOp = 2'b10; bus.Instr_D = mk(5'd1, 5'd2, 16'h1234);
        tick();
        chk("ext_lui", bus.EXT_E, 32'h12340000);
        bus.EXTOp = 2'b00; bus.Instr_D = mk(5'd1, 5'd2, 16'h8000);
        tick();
        chk("ext_zero", bus.EXT_E, 32'h00008000);
        bus.EXTOp = 2'b11;
        tick();
        chk("ext_none", bus.EXT_E, 32'h0);

        // Comparator
        bus.FWD_D1 = 32'hFFFFFFFF; bus.FWD_D2 = 32'hFFFFFFFF;
        #1 chk("cmp_eq_neg", bus.Cmp_Eq, 1'b1);
        chk("cmp_gez_neg", bus.Cmp_GeZ, 1'b0);
        chk("cmp_gtz_neg", bus.Cmp_GtZ, 1'b0);
        tick();
        chk("rs_e_load", bus.RS_E, 32'hFFFFFFFF);
        bus.FWD_D1 = 32'h0;
        #1 chk("cmp_gez_zero", bus.Cmp_GeZ, 1'b1);
        chk("cmp_gtz_zero", bus.Cmp_GtZ, 1'b0);
        chk("cmp_ne", bus.Cmp_Eq, 1'b0);
        bus.FWD_D1 = 32'h5;
        #1 chk("cmp_gtz_pos", bus.Cmp_GtZ, 1'b1);
        tick();

        // Divide: ten busy cycles, stalls, restart ignored
        bus.MD_Start = 1; bus.MD_IsDiv = 1;
        tick();
        bus.MD_Start = 0;
        bus.IsMulDiv_D = 1; bus.PC_D = 32'h400; bus.Instr_D = 32'h2000ABCD;
        n = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.MD_Busy) n++;
            if (i == 4) chk("div_stall", bus.Stall, 1'b1);
            if (i == 5) begin
                chk("div_bubble_instr", bus.Instr_E, 32'h0);
                chk("div_bubble_pc", bus.PC_E, 32'h400);
            end
            bus.MD_Start = (i == 3);
            tick();
        end
        chk("div_busy_cycles", n, 10);
        bus.IsMulDiv_D = 0; bus.MD_Start = 0;
        #1 chk("idle_stall", bus.Stall, 1'b0);

        // Multiply: five busy cycles
        bus.MD_Start = 1; bus.MD_IsDiv = 0;
        tick();
        bus.MD_Start = 0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.MD_Busy) n++;
            tick();
        end
        chk("mul_busy_cycles", n, 5);

        // Flush and external stall
        bus.Instr_D = mk(5'd4, 5'd6, 16'h0042); bus.PC_D = 32'h500;
        bus.Flush_E = 1;
        tick();
        chk("flush_instr", bus.Instr_E, 32'h0);
        chk("flush_pc", bus.PC_E, 32'h500);
        bus.Flush_E = 0;
        tick();
        chk("post_flush_instr", bus.Instr_E, mk(5'd4, 5'd6, 16'h0042));
        bus.Stall_In = 1; bus.Flush_E = 1; bus.PC_D = 32'h504;
        tick();
        chk("stall_flush_instr", bus.Instr_E, 32'h0);
        chk("stall_flush_pc", bus.PC_E, 32'h504);
        bus.Stall_In = 0; bus.Flush_E = 0;
        tick();

        // Reset mid-operation
        bus.MD_Start = 1; bus.MD_IsDiv = 1;
        tick();
        bus.MD_Start = 0;
        tick();
        chk("pre_rst_busy", bus.MD_Busy, 1'b1);
        Reset = 0;
        tick();
        chk("mid_rst_busy", bus.MD_Busy, 1'b0);
        chk("mid_rst_instr", bus.Instr_E, 32'h0);
        bus.MD_Start = 1;
        tick();
        chk("rst_start_ignored", bus.MD_Busy, 1'b0);
        bus.MD_Start = 0;
        Reset = 1;
        bus.Instr_D = mk(5'd8, 5'd9, 16'h0);
        #1 chk("rst_cleared_rd1", bus.RD1D, 32'h0);
        chk("rst_cleared_rd2", bus.RD2D, 32'h0);
        tick(); tick();

        @(negedge Clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
